// File: rtl/otp_session_ctrl_if.sv
// otp_session_ctrl_if
// Bundles every non-clock, non-reset signal of otp_session_ctrl.
//   master : session requester / user side (drives start, lfsr_word, digits;
//            observes lfsr_step, OTP and status outputs)
//   slave  : otp_session_ctrl itself
// Signals:
//   start       session request pulse
//   lfsr_step   advance request to the external LFSR
//   lfsr_word   current external LFSR value
//   digit       user digit, qualified by digit_valid (one-cycle strobe)
//   otp_out     captured OTP, otp_valid marks it as live
//   unlock      correct code entered
//   expired     entry window timed out
//   lockout     too many wrong entries, hold active
//   attempts    wrong entries so far in this session
//   state       FSM state code
interface otp_session_ctrl_if;
  logic        start;
  logic        lfsr_step;
  logic [15:0] lfsr_word;
  logic [3:0]  digit;
  logic        digit_valid;
  logic [15:0] otp_out;
  logic        otp_valid;
  logic        unlock;
  logic        expired;
  logic        lockout;
  logic [1:0]  attempts;
  logic [2:0]  state;

  modport master (
    output start, lfsr_word, digit, digit_valid,
    input  lfsr_step, otp_out, otp_valid, unlock, expired, lockout, attempts, state
  );

  modport slave (
    input  start, lfsr_word, digit, digit_valid,
    output lfsr_step, otp_out, otp_valid, unlock, expired, lockout, attempts, state
  );
endinterface

// File: rtl/otp_session_ctrl.sv
// otp_session_ctrl
// One-time-password session controller. On start it clocks an external LFSR
// LFSR_STEPS times, captures the resulting word as the OTP, then collects four
// user digits inside a TIMEOUT_CYCLES window and compares them to the OTP.
// A match unlocks until the next start; MAX_ATTEMPTS mismatches lock the block
// out for LOCKOUT_CYCLES cycles.
// Ports:
//   clk    single clock
//   reset  synchronous, active-high; clears every register
//   bus    otp_session_ctrl_if.slave (start/LFSR/digit inputs, status outputs)
// Configuration macro:
//   OTP_DECIMAL_EN  when defined, captured OTP nibbles are reduced mod 10 and
//                   digits above 9 are ignored; otherwise raw hex is used.
module otp_session_ctrl #(
  parameter int unsigned LFSR_STEPS     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 750000000,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned MAX_ATTEMPTS   = 3
) (
  input  logic               clk,
  input  logic               reset,
  otp_session_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_ENTRY = 3'd2,
    ST_CHECK = 3'd3,
    ST_PASS  = 3'd4,
    ST_LOCK  = 3'd5
  } state_t;

  // step counter is one bit wider than LFSR_STEPS so the final
  // (non-stepping) capture cycle can be counted without wrapping
  localparam logic [8:0]  STEP_LAST  = 9'(LFSR_STEPS);
  localparam logic [29:0] TIMER_LAST = 30'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST  = 16'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]  ATT_MAX    = 2'(MAX_ATTEMPTS);

  // Converts the raw LFSR word into the OTP value that gets stored.
  function automatic logic [15:0] otp_capture(input logic [15:0] word);
    logic [15:0] res;
    res = word;
`ifdef OTP_DECIMAL_EN
    for (int i = 0; i < 4; i++) begin
      if (word[4*i +: 4] >= 4'd10) begin
        res[4*i +: 4] = word[4*i +: 4] - 4'd10;
      end else begin
        res[4*i +: 4] = word[4*i +: 4];
      end
    end
`endif
    return res;
  endfunction

  state_t      state_r, state_nx_s;
  logic [8:0]  step_cnt_r, step_cnt_nx_s;
  logic [29:0] timer_r, timer_nx_s;
  logic [2:0]  digit_cnt_r, digit_cnt_nx_s;
  logic [15:0] entry_buf_r, entry_buf_nx_s;
  logic [15:0] lock_cnt_r, lock_cnt_nx_s;
  logic [1:0]  attempts_r, attempts_nx_s;
  logic [15:0] otp_out_r, otp_out_nx_s;
  logic        otp_valid_r, otp_valid_nx_s;
  logic        unlock_r, unlock_nx_s;
  logic        expired_r, expired_nx_s;
  logic        lockout_r, lockout_nx_s;
  logic        lfsr_step_r, lfsr_step_nx_s;

  logic        digit_ok_s;
  logic        timeout_s;
  logic        digit_take_s;
  logic        match_s;
  logic        gen_done_s;
  logic        lock_done_s;
  logic [1:0]  attempts_inc_s;

`ifdef OTP_DECIMAL_EN
  assign digit_ok_s = bus.digit_valid && (bus.digit <= 4'd9);
`else
  assign digit_ok_s = bus.digit_valid;
`endif

  // the timeout cycle wins over a digit arriving in the same cycle
  assign timeout_s      = (state_r == ST_ENTRY) && (timer_r == TIMER_LAST);
  assign digit_take_s   = (state_r == ST_ENTRY) && !timeout_s && digit_ok_s;
  assign match_s        = (entry_buf_r == otp_out_r);
  assign gen_done_s     = (step_cnt_r == STEP_LAST);
  assign lock_done_s    = (lock_cnt_r == LOCK_LAST);
  assign attempts_inc_s = attempts_r + 2'd1;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE:  if (bus.start) state_nx_s = ST_GEN; else state_nx_s = ST_IDLE;
      ST_GEN:   if (gen_done_s) state_nx_s = ST_ENTRY; else state_nx_s = ST_GEN;
      ST_ENTRY: begin
        if (timeout_s) begin
          state_nx_s = ST_IDLE;
        end else if (digit_take_s && (digit_cnt_r == 3'd3)) begin
          state_nx_s = ST_CHECK;
        end else begin
          state_nx_s = ST_ENTRY;
        end
      end
      ST_CHECK: begin
        if (match_s) begin
          state_nx_s = ST_PASS;
        end else if (attempts_inc_s == ATT_MAX) begin
          state_nx_s = ST_LOCK;
        end else begin
          state_nx_s = ST_ENTRY;
        end
      end
      ST_PASS:  if (bus.start) state_nx_s = ST_GEN; else state_nx_s = ST_PASS;
      ST_LOCK:  if (lock_done_s) state_nx_s = ST_IDLE; else state_nx_s = ST_LOCK;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    step_cnt_nx_s  = step_cnt_r;
    timer_nx_s     = timer_r;
    digit_cnt_nx_s = digit_cnt_r;
    entry_buf_nx_s = entry_buf_r;
    lock_cnt_nx_s  = lock_cnt_r;
    attempts_nx_s  = attempts_r;
    otp_out_nx_s   = otp_out_r;
    otp_valid_nx_s = otp_valid_r;
    unlock_nx_s    = unlock_r;
    expired_nx_s   = expired_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          expired_nx_s  = 1'b0;
          unlock_nx_s   = 1'b0;
          step_cnt_nx_s = 9'd0;
        end else begin
          step_cnt_nx_s = step_cnt_r;
        end
      end
      ST_GEN: begin
        // capture happens one cycle after the last step, once the
        // external LFSR has settled on its final value
        if (gen_done_s) begin
          otp_out_nx_s   = otp_capture(bus.lfsr_word);
          otp_valid_nx_s = 1'b1;
          timer_nx_s     = 30'd0;
          digit_cnt_nx_s = 3'd0;
        end else begin
          step_cnt_nx_s = step_cnt_r + 9'd1;
        end
      end
      ST_ENTRY: begin
        if (timeout_s) begin
          expired_nx_s   = 1'b1;
          otp_valid_nx_s = 1'b0;
          attempts_nx_s  = 2'd0;
        end else begin
          timer_nx_s = timer_r + 30'd1;
          if (digit_take_s) begin
            entry_buf_nx_s = {entry_buf_r[11:0], bus.digit};
            digit_cnt_nx_s = digit_cnt_r + 3'd1;
          end else begin
            entry_buf_nx_s = entry_buf_r;
          end
        end
      end
      ST_CHECK: begin
        if (match_s) begin
          unlock_nx_s = 1'b1;
        end else begin
          attempts_nx_s = attempts_inc_s;
          if (attempts_inc_s == ATT_MAX) begin
            lock_cnt_nx_s = 16'd0;
          end else begin
            // retry keeps the running timer: the window covers all attempts
            digit_cnt_nx_s = 3'd0;
          end
        end
      end
      ST_PASS: begin
        if (bus.start) begin
          unlock_nx_s    = 1'b0;
          attempts_nx_s  = 2'd0;
          otp_valid_nx_s = 1'b0;
          step_cnt_nx_s  = 9'd0;
        end else begin
          unlock_nx_s = unlock_r;
        end
      end
      ST_LOCK: begin
        if (lock_done_s) begin
          attempts_nx_s  = 2'd0;
          otp_valid_nx_s = 1'b0;
        end else begin
          lock_cnt_nx_s = lock_cnt_r + 16'd1;
        end
      end
      default: begin
        otp_valid_nx_s = 1'b0;
      end
    endcase
    // both strobes are functions of the upcoming state so they register
    // exactly in step with the state they belong to
    lockout_nx_s   = (state_nx_s == ST_LOCK);
    lfsr_step_nx_s = (state_nx_s == ST_GEN) && (step_cnt_nx_s < STEP_LAST);
  end

  // Datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      step_cnt_r  <= 9'd0;
      timer_r     <= 30'd0;
      digit_cnt_r <= 3'd0;
      entry_buf_r <= 16'd0;
      lock_cnt_r  <= 16'd0;
      attempts_r  <= 2'd0;
      otp_out_r   <= 16'd0;
      otp_valid_r <= 1'b0;
      unlock_r    <= 1'b0;
      expired_r   <= 1'b0;
      lockout_r   <= 1'b0;
      lfsr_step_r <= 1'b0;
    end else begin
      step_cnt_r  <= step_cnt_nx_s;
      timer_r     <= timer_nx_s;
      digit_cnt_r <= digit_cnt_nx_s;
      entry_buf_r <= entry_buf_nx_s;
      lock_cnt_r  <= lock_cnt_nx_s;
      attempts_r  <= attempts_nx_s;
      otp_out_r   <= otp_out_nx_s;
      otp_valid_r <= otp_valid_nx_s;
      unlock_r    <= unlock_nx_s;
      expired_r   <= expired_nx_s;
      lockout_r   <= lockout_nx_s;
      lfsr_step_r <= lfsr_step_nx_s;
    end
  end

  assign bus.lfsr_step = lfsr_step_r;
  assign bus.otp_out   = otp_out_r;
  assign bus.otp_valid = otp_valid_r;
  assign bus.unlock    = unlock_r;
  assign bus.expired   = expired_r;
  assign bus.lockout   = lockout_r;
  assign bus.attempts  = attempts_r;
  assign bus.state     = state_r;

endmodule

// File: tb/tb_otp_session_ctrl.sv
// Directed self-checking bench for otp_session_ctrl with LFSR_STEPS=4,
// TIMEOUT_CYCLES=100, LOCKOUT_CYCLES=20, MAX_ATTEMPTS=3. The external LFSR is
// modelled as a word that increments on every clock edge where lfsr_step is
// high, so the captured OTP is seed + 4.
module tb_otp_session_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   step_count;

  otp_session_ctrl_if bus ();

  otp_session_ctrl #(
    .LFSR_STEPS     (4),
    .TIMEOUT_CYCLES (100),
    .LOCKOUT_CYCLES (20),
    .MAX_ATTEMPTS   (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the modelled LFSR advances on edges where lfsr_step was high.
  task automatic tick();
    logic stepped;
    stepped = bus.lfsr_step;
    @(posedge clk);
    #1;
    if (stepped) begin
      bus.lfsr_word = bus.lfsr_word + 16'd1;
      step_count++;
    end
  endtask

  task automatic put_digit(input logic [3:0] d);
    bus.digit       = d;
    bus.digit_valid = 1'b1;
    tick();
    bus.digit_valid = 1'b0;
  endtask

  task automatic put_code(input logic [15:0] code);
    put_digit(code[15:12]);
    put_digit(code[11:8]);
    put_digit(code[7:4]);
    put_digit(code[3:0]);
  endtask

  task automatic wait_state(input logic [2:0] target, input string tag);
    for (int i = 0; i < 30 && bus.state !== target; i++) tick();
    check(tag, 32'(bus.state), 32'(target));
  endtask

  task automatic begin_session(input logic [15:0] seed);
    bus.lfsr_word = seed;
    step_count    = 0;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    int lock_len;
    checks = 0;
    failures = 0;
    step_count = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.lfsr_word = 16'h0000;
    bus.digit = 4'h0;
    bus.digit_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_outs", 32'({bus.otp_out, bus.otp_valid, bus.unlock, bus.expired,
                           bus.lockout, bus.attempts, bus.lfsr_step}), 32'd0);

    // generation: four steps, capture after the last step
    begin_session(16'h1230);
    check("gen_state", 32'(bus.state), 32'd1);
    check("gen_step_hi", 32'(bus.lfsr_step), 32'd1);
    wait_state(3'd2, "gen_to_entry");
    check("gen_step_cnt", 32'(step_count), 32'd4);
    check("gen_otp", 32'(bus.otp_out), 32'h1234);
    check("gen_valid", 32'(bus.otp_valid), 32'd1);
    check("gen_step_lo", 32'(bus.lfsr_step), 32'd0);

    // correct code: CHECK the cycle after the fourth digit, PASS after that
    put_code(16'h1234);
    check("ok_check", 32'(bus.state), 32'd3);
    check("ok_unlock_early", 32'(bus.unlock), 32'd0);
    tick();
    check("ok_pass", 32'(bus.state), 32'd4);
    check("ok_unlock", 32'(bus.unlock), 32'd1);
    tick();
    check("ok_unlock_hold", 32'(bus.unlock), 32'd1);

    // restart from PASS, then three wrong entries -> lockout
    begin_session(16'h5550);
    check("restart_state", 32'(bus.state), 32'd1);
    check("restart_unlock", 32'(bus.unlock), 32'd0);
    wait_state(3'd2, "w_entry");
    check("w_otp", 32'(bus.otp_out), 32'h5554);
    put_code(16'h0000);
    tick();
    check("w1_state", 32'(bus.state), 32'd2);
    check("w1_attempts", 32'(bus.attempts), 32'd1);
    put_code(16'h0000);
    tick();
    check("w2_attempts", 32'(bus.attempts), 32'd2);
    put_code(16'h0000);
    tick();
    check("w3_state", 32'(bus.state), 32'd5);
    check("w3_attempts", 32'(bus.attempts), 32'd3);
    lock_len = 0;
    while (bus.lockout === 1'b1 && lock_len < 40) begin
      lock_len++;
      tick();
    end
    check("lock_len", 32'(lock_len), 32'd20);
    check("lock_exit", 32'({bus.state, bus.attempts, bus.otp_valid, bus.lockout}), 32'd0);

    // timeout: three digits early, fourth lands on the timeout cycle
    begin_session(16'h0990);
    wait_state(3'd2, "to_entry");
    put_digit(4'h0);
    put_digit(4'h9);
    put_digit(4'h9);
    for (int i = 0; i < 96; i++) tick();
    check("to_last_entry", 32'(bus.state), 32'd2);
    check("to_not_expired", 32'(bus.expired), 32'd0);
    put_digit(4'h4);
    check("to_state", 32'(bus.state), 32'd0);
    check("to_expired", 32'(bus.expired), 32'd1);
    check("to_valid", 32'(bus.otp_valid), 32'd0);
    check("to_keep_otp", 32'(bus.otp_out), 32'h0994);

    // reset mid-entry wins over start and digit_valid
    begin_session(16'h7770);
    check("new_expired_clr", 32'(bus.expired), 32'd0);
    wait_state(3'd2, "r_entry");
    put_code(16'h0000);
    tick();
    check("r_attempts", 32'(bus.attempts), 32'd1);
    put_digit(4'h7);
    put_digit(4'h7);
    reset = 1'b1;
    bus.start = 1'b1;
    bus.digit = 4'h7;
    bus.digit_valid = 1'b1;
    tick();
    reset = 1'b0;
    bus.start = 1'b0;
    bus.digit_valid = 1'b0;
    check("r_state", 32'(bus.state), 32'd0);
    check("r_outs", 32'({bus.otp_out, bus.otp_valid, bus.unlock, bus.expired,
                         bus.lockout, bus.attempts, bus.lfsr_step}), 32'd0);
    tick();
    begin_session(16'h4320);
    wait_state(3'd2, "r2_entry");
    check("r2_otp", 32'(bus.otp_out), 32'h4324);
    check("r2_attempts", 32'(bus.attempts), 32'd0);
    put_code(16'h4324);
    tick();
    check("r2_unlock", 32'({bus.state, bus.unlock}), 32'({3'd4, 1'b1}));

    // capture encoding; start is ignored while in ENTRY
    begin_session(16'hABCB);
    wait_state(3'd2, "d_entry");
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("d_start_ignored", 32'(bus.state), 32'd2);
`ifdef OTP_DECIMAL_EN
    check("d_otp", 32'(bus.otp_out), 32'h0125);
    put_digit(4'h0);
    put_digit(4'h1);
    put_digit(4'hC);
    put_digit(4'h2);
    check("d_c_ignored", 32'(bus.state), 32'd2);
    put_digit(4'h5);
`else
    check("d_otp", 32'(bus.otp_out), 32'hABCF);
    put_code(16'hABCF);
`endif
    check("d_check", 32'(bus.state), 32'd3);
    tick();
    check("d_unlock", 32'({bus.state, bus.unlock}), 32'({3'd4, 1'b1}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
